// File: rtl/int_event_queue_pkg.sv
// int_event_queue_pkg: width helpers shared by the event queue and its arbiter
package int_event_queue_pkg;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int cnt_w(input int depth);
        return clog2(depth + 1);
    endfunction
    function automatic int ptr_w(input int depth);
        return clog2(depth);
    endfunction
    function automatic int src_w(input int num_src);
        return (num_src > 1) ? clog2(num_src) : 1;
    endfunction
    function automatic int entry_w(input int sw, input int dw);
        return sw + dw;
    endfunction
endpackage

// File: rtl/int_event_rr_arbiter.sv
// int_event_rr_arbiter: round-robin one-hot grant, priority starts after the last accepted source
module int_event_rr_arbiter
    import int_event_queue_pkg::*;
#(
    parameter int NUM_SRC = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] req,
    input  logic               advance,
    output logic [NUM_SRC-1:0] grant
);
    localparam int SRC_W = src_w(NUM_SRC);
    logic [SRC_W-1:0] ptr, gidx;
    logic [NUM_SRC-1:0] rot;
    int off, sum;
    always_comb begin
        rot = NUM_SRC'({req, req} >> ptr);
        off = 0;
        for (int j = NUM_SRC - 1; j >= 0; j--) if (rot[j]) off = j;
        sum = int'(ptr) + off;
        gidx = SRC_W'((sum >= NUM_SRC) ? sum - NUM_SRC : sum);
        grant = (|rot) ? (NUM_SRC'(1) << gidx) : '0;
    end
    always_ff @(posedge clock) begin
        if (reset) ptr <= '0;
        else if (advance) ptr <= (int'(gidx) == NUM_SRC - 1) ? '0 : gidx + 1'b1;
    end
endmodule

// File: rtl/int_event_queue.sv
// int_event_queue: multi-source event FIFO with round-robin intake, show-ahead output,
// watermark and sticky overflow status
module int_event_queue
    import int_event_queue_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 5,
    parameter int NUM_SRC    = 2,
    localparam int CNT_W     = cnt_w(DEPTH),
    localparam int PTR_W     = ptr_w(DEPTH),
    localparam int SRC_W     = src_w(NUM_SRC)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SRC_W-1:0]              out_src,
    input  logic [CNT_W-1:0]              wmark_level,
    output logic [CNT_W-1:0]              count,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic                          wmark_reached,
    input  logic                          clr_overflow,
    output logic                          overflow_sticky
);
    localparam int ENTRY_W = entry_w(SRC_W, DATA_WIDTH);
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [NUM_SRC-1:0] grant;
    logic [SRC_W-1:0] gsel;
    logic [DATA_WIDTH-1:0] gdata;
    logic push, pop;
    int_event_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
        .clock(clock), .reset(reset), .req(src_valid), .advance(push), .grant(grant)
    );
    // Reset masks the visible state so outputs are idle even before the first reset edge
    assign count         = reset ? '0 : cnt;
    assign fifo_full     = count == CNT_W'(DEPTH);
    assign fifo_empty    = count == '0;
    assign out_valid     = !fifo_empty;
    assign wmark_reached = count >= wmark_level;
    assign src_ready     = grant & {NUM_SRC{!fifo_full && !reset}};
    assign push          = |src_ready;
    assign pop           = out_valid && out_ready;
    assign {out_src, out_data} = mem[rd_ptr];
    always_comb begin
        gsel  = '0;
        gdata = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                gsel  = SRC_W'(i);
                gdata = src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {gsel, gdata};
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            cnt             <= '0;
            overflow_sticky <= 1'b0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
            if (|src_valid && fifo_full) overflow_sticky <= 1'b1;
            else if (clr_overflow) overflow_sticky <= 1'b0;
        end
    end
endmodule

// File: tb/tb_int_event_queue.sv
// tb_int_event_queue: directed scenarios plus random traffic against a queue-based reference model
module tb_int_event_queue;
    localparam int DW = 8, DEPTH = 5, NS = 2, CW = 3;
    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset, out_ready, clr_overflow;
    logic [NS-1:0] src_valid, src_ready;
    logic [NS*DW-1:0] src_data;
    logic out_valid, fifo_full, fifo_empty, wmark_reached, overflow_sticky;
    logic [DW-1:0] out_data;
    logic [0:0] out_src;
    logic [CW-1:0] wmark_level, count;
    int_event_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_SRC(NS)) dut (
        .clock(clock), .reset(reset), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src), .wmark_level(wmark_level), .count(count),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .wmark_reached(wmark_reached),
        .clr_overflow(clr_overflow), .overflow_sticky(overflow_sticky)
    );
    int total = 0, bad = 0;
    logic [DW:0] exp_q[$];
    int mcount = 0, rr = 0, g;
    bit msticky = 0, mpush, mpop;
    task automatic chk(input string n, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, act, exp);
        end
    endtask
    function automatic int grant_of(input logic [NS-1:0] v, input int r);
        for (int k = 0; k < NS; k++) if (v[(r + k) % NS]) return (r + k) % NS;
        return -1;
    endfunction
    // Reference model: advances on each rising edge from the inputs alone
    always @(posedge clock) begin
        if (reset) begin
            mcount = 0; rr = 0; msticky = 0; exp_q.delete();
        end else begin
            g = grant_of(src_valid, rr);
            mpush = g >= 0 && mcount < DEPTH;
            mpop = mcount > 0 && out_ready;
            if (|src_valid && mcount == DEPTH) msticky = 1;
            else if (clr_overflow) msticky = 0;
            if (mpush) begin
                exp_q.push_back({1'(g), src_data[g*DW +: DW]});
                rr = (g + 1) % NS;
            end
            mcount = mcount + int'(mpush) - int'(mpop);
        end
    end
    always @(negedge clock) begin
        int ec, eg;
        logic [NS-1:0] er;
        ec = reset ? 0 : mcount;
        eg = grant_of(src_valid, rr);
        er = (reset || ec == DEPTH || eg < 0) ? '0 : NS'(1 << eg);
        chk("count", count, ec);
        chk("out_valid", out_valid, ec > 0);
        chk("fifo_full", fifo_full, ec == DEPTH);
        chk("fifo_empty", fifo_empty, ec == 0);
        chk("wmark_reached", wmark_reached, ec >= int'(wmark_level));
        chk("overflow_sticky", overflow_sticky, msticky);
        chk("src_ready", src_ready, er);
    end
    // Scoreboard monitor: every consumed head is matched against the oldest expected entry
    always @(negedge clock) begin
        logic [DW:0] e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("pop_without_expected", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e[DW-1:0]);
                chk("out_src", out_src, e[DW]);
            end
        end
    end
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask
    task automatic set(input logic [NS-1:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic rdy, input logic clr = 1'b0);
        src_valid = v; src_data = {d1, d0}; out_ready = rdy; clr_overflow = clr;
    endtask
    initial begin
        reset = 1'b1; wmark_level = '0;
        set(2'b00, 8'h0, 8'h0, 1'b0);
        tick(3);
        reset = 1'b0;
        set(2'b01, 8'hA5, 8'h0, 1'b0);
        tick();
        set(2'b00, 8'h0, 8'h0, 1'b0);
        tick();
        #3;
        chk("single_out_valid", out_valid, 1);
        chk("single_out_data", out_data, 8'hA5);
        chk("single_out_src", out_src, 0);
        chk("single_count", count, 1);
        set(2'b00, 8'h0, 8'h0, 1'b1);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            set(2'b01, 8'(8'h10 + i), 8'h0, 1'b0);
            tick();
        end
        #3;
        chk("fill_full", fifo_full, 1);
        chk("fill_count", count, DEPTH);
        set(2'b01, 8'h77, 8'h0, 1'b0);
        #1;
        chk("fill_blocked_ready", src_ready, 0);
        tick();
        #3;
        chk("fill_overflow", overflow_sticky, 1);
        set(2'b01, 8'h77, 8'h0, 1'b0, 1'b1);
        tick();
        #3;
        chk("set_beats_clear", overflow_sticky, 1);
        set(2'b00, 8'h0, 8'h0, 1'b0, 1'b1);
        tick();
        #3;
        chk("clear_overflow", overflow_sticky, 0);
        set(2'b00, 8'h0, 8'h0, 1'b1);
        tick(DEPTH);
        set(2'b01, 8'h30, 8'h0, 1'b0);
        tick();
        for (int i = 0; i < 12; i++) begin
            set(2'b01, 8'(8'h40 + i), 8'h0, 1'b1);
            tick();
            chk("wrap_count", count, 1);
        end
        set(2'b00, 8'h0, 8'h0, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set(2'b11, 8'(8'h50 + i), 8'(8'h60 + i), 1'b1);
            tick();
        end
        set(2'b00, 8'h0, 8'h0, 1'b1);
        tick(2);
        wmark_level = 3'd3;
        for (int i = 0; i < 3; i++) begin
            set(2'b10, 8'h0, 8'(8'h70 + i), 1'b0);
            tick();
            #3;
            chk("wmark_ramp", wmark_reached, i == 2);
        end
        set(2'b00, 8'h0, 8'h0, 1'b1);
        tick();
        #3;
        chk("wmark_fall", wmark_reached, 0);
        set(2'b01, 8'h81, 8'h0, 1'b0);
        tick();
        #3;
        chk("pre_reset_count", count, 3);
        reset = 1'b1;
        set(2'b00, 8'h0, 8'h0, 1'b0);
        tick();
        reset = 1'b0;
        #3;
        chk("reset_count", count, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_overflow", overflow_sticky, 0);
        for (int i = 0; i < 500; i++) begin
            reset = ($urandom_range(0, 60) == 0);
            wmark_level = CW'($urandom_range(0, 7));
            set(NS'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 5) == 0));
            tick();
        end
        reset = 1'b0;
        set(2'b00, 8'h0, 8'h0, 1'b1);
        tick(DEPTH + 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/int_event_queue.md
INT_EVENT_QUEUE -- requirements
Module: int_event_queue

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the event payload width in bits (1..64).
REQ-002 Parameter DEPTH, default 5, SHALL set the queue capacity in entries (2..256); non-power-of-2 values are legal.
REQ-003 Parameter NUM_SRC, default 2, SHALL set the number of event source ports (1..8).
REQ-004 Derived constants SHALL be: CNT_W = clog2(DEPTH+1), PTR_W = clog2(DEPTH), SRC_W = max(1, clog2(NUM_SRC)).
REQ-005 Port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port src_valid, input, NUM_SRC bits: per-source event request.
REQ-008 Port src_data, input, NUM_SRC*DATA_WIDTH bits: per-source payload; source i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port src_ready, output, NUM_SRC bits: per-source accept; combinational from src_valid and state.
REQ-010 Port out_valid, output, 1 bit: the head entry is valid.
REQ-011 Port out_ready, input, 1 bit: the consumer accepts the head.
REQ-012 Port out_data, output, DATA_WIDTH bits: the head payload.
REQ-013 Port out_src, output, SRC_W bits: the head source index.
REQ-014 Port wmark_level, input, CNT_W bits: the runtime watermark threshold.
REQ-015 Port count, output, CNT_W bits: the current occupancy.
REQ-016 Ports fifo_full, fifo_empty and wmark_reached, outputs, 1 bit each: status flags.
REQ-017 Port clr_overflow, input, 1 bit: clears overflow_sticky.
REQ-018 Port overflow_sticky, output, 1 bit: records that a source was back-pressured while the queue was full.

Function
REQ-019 Each cycle, at most one source SHALL be granted, using round-robin arbitration; priority starts at the index after the last accepted source, and index 0 has top priority after reset.
REQ-020 src_ready[i] SHALL be 1 only when source i is granted, src_valid[i]=1 and fifo_full=0.
REQ-021 A push SHALL write {granted index, payload} at wr_ptr and advance wr_ptr, which wraps from DEPTH-1 to 0.
REQ-022 A pop SHALL occur when out_valid=1 and out_ready=1; it advances rd_ptr, which wraps from DEPTH-1 to 0.
REQ-023 The queue SHALL be show-ahead: out_valid=!fifo_empty, and out_data/out_src SHALL reflect the entry at rd_ptr with no read latency.
REQ-024 The first push into an empty queue SHALL produce out_valid=1 in the cycle after the push.
REQ-025 count SHALL become count+1 on push only, count-1 on pop only, and stay unchanged on simultaneous push and pop.
REQ-026 When full, pushes SHALL be blocked even if a pop occurs in the same cycle; a pop while full frees a slot for the next cycle.
REQ-027 out_ready while empty SHALL have no effect; count never underflows and rd_ptr does not move.
REQ-028 fifo_full SHALL equal (count==DEPTH), and fifo_empty SHALL equal (count==0).
REQ-029 wmark_reached SHALL equal (count >= wmark_level); a wmark_level of 0 forces it to 1, and wmark_level > DEPTH forces it to 0.
REQ-030 overflow_sticky SHALL set on the cycle after any src_valid bit is 1 while fifo_full=1.
REQ-031 overflow_sticky SHALL clear on the cycle after clr_overflow=1; if set and clear occur in the same cycle, set wins.
REQ-032 Pending sources SHALL NOT be lost: a valid that is not accepted is retried by the source, and the arbiter guarantees service within NUM_SRC accepted pushes.

Reset
REQ-033 While reset=1 at a clock edge, the block SHALL set: wr_ptr=0, rd_ptr=0, count=0, the arbiter pointer to source 0, and overflow_sticky=0.
REQ-034 During and after reset, outputs SHALL be: out_valid=0, fifo_empty=1, fifo_full=0, src_ready=0, and wmark_reached=(wmark_level==0).
REQ-035 Reset mid-operation SHALL discard all entries; storage contents need no reset and SHALL never be observable while out_valid=0.

Structure
REQ-036 A shared package SHALL hold the clog2 function, the CNT_W/PTR_W/SRC_W derivations, and the entry-layout constant (ENTRY_W = SRC_W + DATA_WIDTH).
REQ-037 The round-robin arbiter SHALL be a separate sub-module named int_event_rr_arbiter, with inputs req[NUM_SRC] and advance, and output grant[NUM_SRC] (one-hot).
REQ-038 Storage SHALL be an inferred register array of DEPTH x ENTRY_W, with synchronous write and combinational read at rd_ptr.

Verification
REQ-039 Bench scenarios (DEPTH=5, NUM_SRC=2, DATA_WIDTH=8) SHALL cover:
- Single push: src_valid=01, data 0xA5, then idle -> next cycle out_valid=1, out_data=0xA5, out_src=0, count=1.
- Fill: 5 pushes from src0 with out_ready=0 -> fifo_full=1, count=5; a 6th src_valid -> src_ready=00, overflow_sticky=1 next cycle.
- Wrap: 12 push/pop pairs at the same rate -> count stays 1 and data order is preserved across the pointer wrap at 4->0.
- Fairness: src_valid=11 held for 4 cycles, out_ready=1 -> out_src sequence 0,1,0,1.
- Watermark: wmark_level=3, 3 pushes -> wmark_reached rises on the third count update; one pop -> falls.
- Reset mid-operation: count=3, reset pulse -> next cycle count=0, out_valid=0, overflow_sticky=0; clr_overflow coincident with a set keeps overflow_sticky=1.
